// File: rtl/pdu_dmem_burst_if.sv
// Command, write/read stream and data-memory port bundle for the PDU burst engine.
// The engine takes the slave view; the PDU command logic and memory take the master view.
interface pdu_dmem_burst_if #(
    parameter int DEPTH = 12,
    parameter int LEN_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [DEPTH-1:0] cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_data;
    logic             busy;
    logic             done;
    logic [DEPTH-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, mem_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, mem_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/pdu_dmem_burst.sv
// Burst engine in front of the PDU data memory: word-by-word write/read bursts with
// a 2-entry read buffer that hides the memory's 1-cycle read latency and backpressure.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a burst command
// ST_WRITE | accepting write words, one memory write per handshake
// ST_READ  | issuing reads and returning words through the buffer
// ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module pdu_dmem_burst #(
    parameter int DEPTH = 12,
    parameter int LEN_W = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    pdu_dmem_burst_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DEPTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_W:0]   LEN_ONE  = 1;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] addr_q, addr_d;
    logic [LEN_W:0]   remain_q, remain_d;
    logic [LEN_W:0]   issued_left_q, issued_left_d;
    logic             inflight_q, inflight_d;

    logic [31:0]      fifo_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       fifo_cnt_q;

    logic [2:0]       occ;
    logic             rd_valid_int;
    logic [31:0]      head;
    logic             rd_hs, fifo_pop, push, issue, last_pop;

    // Words in flight count against buffer space so a stalled consumer never overflows it.
    // With an empty buffer the returning memory word is presented directly (bypass).
    always_comb begin
        occ          = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
        rd_valid_int = (state_q == ST_READ) && ((fifo_cnt_q != 2'd0) || inflight_q);
        head         = (fifo_cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : bus.mem_rdata;
        rd_hs        = rd_valid_int && bus.rd_ready;
        fifo_pop     = rd_hs && (fifo_cnt_q != 2'd0);
        push         = inflight_q && !(rd_hs && (fifo_cnt_q == 2'd0));
        issue        = (state_q == ST_READ) && (issued_left_q != '0) && (occ < 3'd2);
        last_pop     = rd_hs && (issued_left_q == '0) && (occ == 3'd1);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remain_d      = remain_q;
        issued_left_d = issued_left_q;
        inflight_d    = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;
        bus.busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    addr_d        = bus.cmd_addr;
                    remain_d      = {1'b0, bus.cmd_len};
                    issued_left_d = {1'b0, bus.cmd_len} + LEN_ONE;
                    state_d       = bus.cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                bus.wr_ready  = 1'b1;
                bus.mem_we    = bus.wr_valid;
                bus.mem_wdata = bus.wr_data;
                if (bus.wr_valid) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (remain_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        remain_d = remain_q - LEN_ONE;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d        = addr_q + ADDR_ONE;
                    issued_left_d = issued_left_q - LEN_ONE;
                    inflight_d    = 1'b1;
                end
                if (last_pop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_addr = addr_q;
    assign bus.rd_valid = rd_valid_int;
    assign bus.rd_data  = rd_valid_int ? head : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remain_q      <= '0;
            issued_left_q <= '0;
            inflight_q    <= 1'b0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remain_q      <= remain_d;
            issued_left_q <= issued_left_d;
            inflight_q    <= inflight_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

endmodule

// File: tb/tb_pdu_dmem_burst.sv
// Randomized bench for pdu_dmem_burst: a word-array reference of memory contents
// predicts write addresses/data and the read-back stream; timing rules checked per burst.
module tb_pdu_dmem_burst;
    localparam int DEPTH  = 12;
    localparam int LEN_W  = 12;
    localparam int NWORDS = 1 << DEPTH;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    pdu_dmem_burst_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    pdu_dmem_burst #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // Data memory: synchronous write, registered read.
    logic [31:0] mem [NWORDS];
    always @(posedge sys_clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    logic [31:0] shadow [NWORDS];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_cmd();
        bus.cmd_valid = ($urandom_range(3) == 0);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = DEPTH'($urandom);
        bus.cmd_len   = LEN_W'($urandom_range(7));
    endtask

    // Completion cycle and the cycle after it; junk on cmd/wr inputs must be ignored.
    task automatic finish_burst(input int cyc, input int exp_cyc);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'($urandom);
        bus.wr_valid  = 1'b1;
        bus.rd_ready  = 1'b1;
        #1;
        check("done_pulse", {bus.done, bus.busy, bus.cmd_ready, bus.mem_we, bus.rd_valid, bus.wr_ready},
              6'b110000);
        if (exp_cyc >= 0) check("done_cycle", cyc, exp_cyc);
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b0;
        #1;
        check("back_idle", {bus.done, bus.busy, bus.cmd_ready, bus.mem_we, bus.rd_valid, bus.wr_ready},
              6'b001000);
    endtask

    // dbase >= 0 gives data dbase, dbase+1, ...; otherwise random words.
    task automatic wr_burst(input int addr, input int len, input int gap_pct, input int dbase,
                            input bit timed);
        int          idx = 0;
        int          cyc = 1;
        logic [31:0] rnd;
        logic [31:0] d;
        rnd = $urandom;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = DEPTH'(addr);
        bus.cmd_len   = LEN_W'(len);
        #1;
        check("wr_cmd_ready", bus.cmd_ready, 1);
        @(negedge sys_clk);
        while (idx <= len && cyc < 4 * (len + 1) + 20) begin
            scramble_cmd();
            d            = (dbase >= 0) ? 32'(dbase + idx) : rnd;
            bus.wr_valid = ($urandom_range(99) >= gap_pct);
            bus.wr_data  = bus.wr_valid ? d : $urandom;
            #1;
            check("wr_state", {bus.wr_ready, bus.busy, bus.cmd_ready, bus.done, bus.rd_valid}, 5'b11000);
            check("wr_we", bus.mem_we, bus.wr_valid);
            if (bus.wr_valid) begin
                check("wr_addr", bus.mem_addr, (addr + idx) % NWORDS);
                check("wr_wdata", bus.mem_wdata, d);
                shadow[(addr + idx) % NWORDS] = d;
                idx++;
                rnd = $urandom;
            end
            @(negedge sys_clk);
            cyc++;
        end
        if (idx <= len) check("wr_timeout", idx, len + 1);
        bus.wr_valid = 1'b0;
        finish_burst(cyc, timed ? len + 2 : -1);
    endtask

    // mode 0: rd_ready held 1; 1: random; 2: 0 on cycles 2-7 then 1.
    // Returns early (aborted=1) at the start of the cycle after abort_after words were popped.
    task automatic rd_burst(input int addr, input int len, input int mode, input int abort_after,
                            output bit aborted);
        int               pops   = 0;
        int               issued = 0;
        int               cyc    = 1;
        logic [DEPTH-1:0] prev_addr;
        aborted = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = DEPTH'(addr);
        bus.cmd_len   = LEN_W'(len);
        #1;
        check("rd_cmd_ready", bus.cmd_ready, 1);
        @(negedge sys_clk);
        prev_addr = DEPTH'(addr);
        while (pops <= len && cyc < 8 * (len + 1) + 40) begin
            if (pops == abort_after) begin
                aborted = 1'b1;
                return;
            end
            scramble_cmd();
            bus.wr_valid = 1'($urandom);
            bus.wr_data  = $urandom;
            case (mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = 1'($urandom_range(1));
                default: bus.rd_ready = !(cyc >= 2 && cyc <= 7);
            endcase
            #1;
            if (bus.mem_addr != prev_addr) issued++;
            prev_addr = bus.mem_addr;
            check("rd_state", {bus.busy, bus.cmd_ready, bus.done, bus.mem_we, bus.wr_ready}, 5'b10000);
            check("rd_outstanding_le2", (issued - pops) <= 2, 1);
            check("rd_issued_le_len", issued <= len + 1, 1);
            if (mode == 0) check("rd_valid_timing", bus.rd_valid, cyc >= 2);
            if (cyc == 1) check("rd_valid_c1", bus.rd_valid, 0);
            if (bus.rd_valid && bus.rd_ready) begin
                check("rd_data", bus.rd_data, shadow[(addr + pops) % NWORDS]);
                pops++;
            end
            @(negedge sys_clk);
            cyc++;
        end
        if (pops <= len) check("rd_timeout", pops, len + 1);
        finish_burst(cyc, (mode == 0) ? len + 3 : -1);
    endtask

    initial begin
        bit ab;
        int a, l;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        #2;
        check("reset_ctrl", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_we},
              6'b100000);
        check("reset_addr", bus.mem_addr, 0);
        check("reset_rdata", bus.rd_data, 0);
        check("reset_wdata", bus.mem_wdata, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;

        // Full-length burst (cmd_len all ones) fills every word of memory and wraps.
        wr_burst(32'h123, NWORDS - 1, 10, -1, 1'b0);

        wr_burst(32'h010, 3, 0, 32'hA0, 1'b1);
        rd_burst(32'h010, 3, 0, -1, ab);
        rd_burst(32'h010, 3, 2, -1, ab);

        wr_burst(32'hFFE, 3, 0, -1, 1'b1);
        rd_burst(32'hFFE, 3, 0, -1, ab);

        rd_burst(32'h500, 0, 1, -1, ab);
        rd_burst(32'h010, 0, 0, -1, ab);

        // Asynchronous reset in the middle of a read burst.
        rd_burst(32'h200, 7, 0, 2, ab);
        check("abort_reached", ab, 1);
        bus.rd_ready  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        #1;
        check("pre_rst_busy", {bus.busy, bus.rd_valid}, 2'b11);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done, bus.mem_we},
              6'b100000);
        check("rst_mid_addr", bus.mem_addr, 0);
        check("rst_mid_rdata", bus.rd_data, 0);
        @(negedge sys_clk);
        bus.wr_valid = 1'b0;
        sys_rst_n    = 1'b1;
        #1;
        check("rst_release_idle", {bus.cmd_ready, bus.busy}, 2'b10);
        wr_burst(32'h200, 5, 20, -1, 1'b0);
        rd_burst(32'h1FE, 9, 1, -1, ab);

        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(NWORDS - 1);
            l = $urandom_range(15);
            if ($urandom_range(1) == 1) wr_burst(a, l, 30, -1, 1'b0);
            else                        rd_burst(a, l, $urandom_range(2), -1, ab);
        end

        rd_burst(32'h123, NWORDS - 1, 1, -1, ab);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
